// File: rtl/decode_stage.sv
// Single-stage registered instruction decoder with valid/ready handshake,
// HALT latch, flush and a saturating count of delivered results.
module decode_stage #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 5,
    parameter int REG_W   = 3,
    parameter int IMM_W   = 4,
    parameter int TGT_W   = 6,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   opcode,
    output logic               amode,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [IMM_W-1:0]   imm,
    output logic [TGT_W-1:0]   tgt,
    output logic [REG_W-1:0]   shamt,
    output logic [5:0]         fld_en,
    output logic               illegal,
    output logic               halted,
    output logic [CNT_W-1:0]   dec_count
);

    if (INSTR_W < OPC_W + 1 + 3*REG_W + 1 ||
        TGT_W > INSTR_W - OPC_W - 1 ||
        IMM_W > INSTR_W - OPC_W - 1) begin : g_param_check
        $error("decode_stage: illegal parameter combination");
    end

    // Top bit of the operand area, just below the amode bit.
    localparam int P = INSTR_W - OPC_W - 2;

    localparam logic [OPC_W-1:0] OP_MOVE  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_DIV   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_INC   = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_DEC   = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_NOT   = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_XOR   = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_JUMP  = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_BEQZ  = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_ASHL  = OPC_W'(16);
    localparam logic [OPC_W-1:0] OP_ASHR  = OPC_W'(17);
    localparam logic [OPC_W-1:0] OP_LSHL  = OPC_W'(18);
    localparam logic [OPC_W-1:0] OP_LSHR  = OPC_W'(19);
    localparam logic [OPC_W-1:0] OP_ROTL  = OPC_W'(20);
    localparam logic [OPC_W-1:0] OP_ROTR  = OPC_W'(21);
    localparam logic [OPC_W-1:0] OP_BC    = OPC_W'(22);
    localparam logic [OPC_W-1:0] OP_BAUX  = OPC_W'(23);
    localparam logic [OPC_W-1:0] OP_BPAR  = OPC_W'(24);
    localparam logic [OPC_W-1:0] OP_CMP   = OPC_W'(25);
    localparam logic [OPC_W-1:0] OP_HALT  = '1;

    // fld_en bit positions: {shamt,tgt,imm,rs2,rs1,rd}
    localparam logic [5:0] EN_RD  = 6'b000001;
    localparam logic [5:0] EN_RS1 = 6'b000010;
    localparam logic [5:0] EN_RS2 = 6'b000100;
    localparam logic [5:0] EN_IMM = 6'b001000;
    localparam logic [5:0] EN_TGT = 6'b010000;
    localparam logic [5:0] EN_SH  = 6'b100000;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [REG_W-1:0] fa, fb, fc;
    logic [IMM_W-1:0] fil, fih;
    logic [TGT_W-1:0] ft;
    logic             fam;

    assign fam = instr[P+1];
    assign fa  = instr[P -: REG_W];
    assign fb  = instr[P-REG_W -: REG_W];
    assign fc  = instr[P-2*REG_W -: REG_W];
    assign fil = instr[IMM_W-1:0];
    assign fih = instr[P -: IMM_W];
    assign ft  = instr[P -: TGT_W];

    logic [OPC_W-1:0] opcode_p0;
    logic             amode_p0, illegal_p0;
    logic [REG_W-1:0] rd_p0, rs1_p0, rs2_p0, shamt_p0;
    logic [IMM_W-1:0] imm_p0;
    logic [TGT_W-1:0] tgt_p0;
    logic [5:0]       fld_en_p0;

    // Combinational field extraction; unused fields are forced to zero.
    always_comb begin
        opcode_p0  = instr[INSTR_W-1 -: OPC_W];
        amode_p0   = 1'b0;
        illegal_p0 = 1'b0;
        rd_p0      = '0;
        rs1_p0     = '0;
        rs2_p0     = '0;
        shamt_p0   = '0;
        imm_p0     = '0;
        tgt_p0     = '0;
        fld_en_p0  = '0;
        case (opcode_p0)
            OP_MOVE: begin
                amode_p0 = fam;
                rd_p0    = fa;
                if (fam) begin
                    imm_p0    = fil;
                    fld_en_p0 = EN_RD | EN_IMM;
                end else begin
                    rs1_p0    = fb;
                    fld_en_p0 = EN_RD | EN_RS1;
                end
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_CMP: begin
                amode_p0 = fam;
                rd_p0    = fa;
                rs1_p0   = fb;
                if (fam) begin
                    imm_p0    = fil;
                    fld_en_p0 = EN_RD | EN_RS1 | EN_IMM;
                end else begin
                    rs2_p0    = fc;
                    fld_en_p0 = EN_RD | EN_RS1 | EN_RS2;
                end
            end
            OP_INC, OP_DEC, OP_NOT: begin
                amode_p0 = fam;
                if (fam) begin
                    imm_p0    = fih;
                    fld_en_p0 = EN_IMM;
                end else begin
                    rd_p0     = fa;
                    fld_en_p0 = EN_RD;
                end
            end
            OP_LOAD: begin
                rd_p0     = fa;
                imm_p0    = fil;
                fld_en_p0 = EN_RD | EN_IMM;
            end
            OP_STORE: begin
                tgt_p0    = ft;
                rd_p0     = instr[REG_W-1:0];
                fld_en_p0 = EN_TGT | EN_RD;
            end
            OP_JUMP, OP_BEQZ, OP_BC, OP_BAUX, OP_BPAR: begin
                tgt_p0    = ft;
                fld_en_p0 = EN_TGT;
            end
            OP_ASHL, OP_ASHR, OP_LSHL, OP_LSHR, OP_ROTL, OP_ROTR: begin
                amode_p0 = fam;
                shamt_p0 = fb;
                if (fam) begin
                    imm_p0    = fih;
                    fld_en_p0 = EN_SH | EN_IMM;
                end else begin
                    rd_p0     = fa;
                    fld_en_p0 = EN_SH | EN_RD;
                end
            end
            OP_HALT: ;
            default: illegal_p0 = 1'b1;
        endcase
    end

    logic             vld_p1, halted_p1;
    logic [CNT_W-1:0] count_p1;
    logic [OPC_W-1:0] opcode_p1;
    logic             amode_p1, illegal_p1;
    logic [REG_W-1:0] rd_p1, rs1_p1, rs2_p1, shamt_p1;
    logic [IMM_W-1:0] imm_p1;
    logic [TGT_W-1:0] tgt_p1;
    logic [5:0]       fld_en_p1;
    logic             accept, handoff;

    assign in_ready = !reset && !halted_p1 && (!vld_p1 || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = vld_p1 && out_ready;

    // Output stage: capture decode on accept, track handoff, halt and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1     <= 1'b0;
            halted_p1  <= 1'b0;
            count_p1   <= '0;
            opcode_p1  <= '0;
            amode_p1   <= 1'b0;
            illegal_p1 <= 1'b0;
            rd_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            shamt_p1   <= '0;
            imm_p1     <= '0;
            tgt_p1     <= '0;
            fld_en_p1  <= '0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            halted_p1 <= 1'b0;
        end else begin
            if (handoff) begin
                count_p1 <= sat_inc(count_p1);
            end
            if (accept) begin
                vld_p1     <= 1'b1;
                opcode_p1  <= opcode_p0;
                amode_p1   <= amode_p0;
                illegal_p1 <= illegal_p0;
                rd_p1      <= rd_p0;
                rs1_p1     <= rs1_p0;
                rs2_p1     <= rs2_p0;
                shamt_p1   <= shamt_p0;
                imm_p1     <= imm_p0;
                tgt_p1     <= tgt_p0;
                fld_en_p1  <= fld_en_p0;
                if (opcode_p0 == OP_HALT) begin
                    halted_p1 <= 1'b1;
                end
            end else if (handoff) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign halted    = halted_p1;
    assign dec_count = count_p1;
    assign opcode    = opcode_p1;
    assign amode     = amode_p1;
    assign illegal   = illegal_p1;
    assign rd        = rd_p1;
    assign rs1       = rs1_p1;
    assign rs2       = rs2_p1;
    assign shamt     = shamt_p1;
    assign imm       = imm_p1;
    assign tgt       = tgt_p1;
    assign fld_en    = fld_en_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a transaction-level reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_decode_stage;

    localparam int IW = 16;
    localparam int OW = 5;
    localparam int RW = 3;
    localparam int MW = 4;
    localparam int TW = 6;
    localparam int P  = IW - OW - 2;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [IW-1:0] instr;

    logic       in_ready, out_valid, amode, illegal, halted;
    logic [4:0] opcode;
    logic [2:0] rd, rs1, rs2, shamt;
    logic [3:0] imm;
    logic [5:0] tgt, fld_en;
    logic [7:0] dec_count;

    logic       in_ready_b, out_valid_b, amode_b, illegal_b, halted_b;
    logic [4:0] opcode_b;
    logic [2:0] rd_b, rs1_b, rs2_b, shamt_b;
    logic [3:0] imm_b;
    logic [5:0] tgt_b, fld_en_b;
    logic [1:0] dec_count_b;

    decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .instr(instr), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .amode(amode), .rd(rd),
        .rs1(rs1), .rs2(rs2), .imm(imm), .tgt(tgt), .shamt(shamt),
        .fld_en(fld_en), .illegal(illegal), .halted(halted),
        .dec_count(dec_count)
    );

    decode_stage #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_b), .instr(instr), .out_valid(out_valid_b),
        .out_ready(out_ready), .opcode(opcode_b), .amode(amode_b), .rd(rd_b),
        .rs1(rs1_b), .rs2(rs2_b), .imm(imm_b), .tgt(tgt_b), .shamt(shamt_b),
        .fld_en(fld_en_b), .illegal(illegal_b), .halted(halted_b),
        .dec_count(dec_count_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] opc;
        logic       am;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [3:0] imm;
        logic [5:0] tgt;
        logic [2:0] sh;
        logic [5:0] en;
        logic       ill;
    } dec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set rules, using integer arithmetic.
    function automatic dec_t model_dec(input int w);
        dec_t d;
        int op, am, a, b, c, il, ih, t;
        d  = '0;
        op = (w >> (IW - OW)) % (1 << OW);
        am = (w >> (P + 1)) % 2;
        a  = (w >> (P - RW + 1)) % 8;
        b  = (w >> (P - 2*RW + 1)) % 8;
        c  = (w >> (P - 3*RW + 1)) % 8;
        il = w % 16;
        ih = (w >> (P - MW + 1)) % 16;
        t  = (w >> (P - TW + 1)) % 64;
        d.opc = 5'(op);
        if (op == 31) begin
            d.en = 6'd0;
        end else if (op == 0) begin
            d.am = 1'(am);
            d.rd = 3'(a);
            if (am == 1) begin d.imm = 4'(il); d.en = 6'd9; end
            else begin d.rs1 = 3'(b); d.en = 6'd3; end
        end else if (op inside {1, 2, 3, 4, 7, 8, 10, 25}) begin
            d.am = 1'(am);
            d.rd = 3'(a);
            d.rs1 = 3'(b);
            if (am == 1) begin d.imm = 4'(il); d.en = 6'd11; end
            else begin d.rs2 = 3'(c); d.en = 6'd7; end
        end else if (op inside {5, 6, 9}) begin
            d.am = 1'(am);
            if (am == 1) begin d.imm = 4'(ih); d.en = 6'd8; end
            else begin d.rd = 3'(a); d.en = 6'd1; end
        end else if (op == 11) begin
            d.rd = 3'(a); d.imm = 4'(il); d.en = 6'd9;
        end else if (op == 12) begin
            d.tgt = 6'(t); d.rd = 3'(w % 8); d.en = 6'd17;
        end else if (op inside {13, 14, 22, 23, 24}) begin
            d.tgt = 6'(t); d.en = 6'd16;
        end else if (op >= 16 && op <= 21) begin
            d.am = 1'(am);
            d.sh = 3'(b);
            if (am == 1) begin d.imm = 4'(ih); d.en = 6'd40; end
            else begin d.rd = 3'(a); d.en = 6'd33; end
        end else begin
            d.ill = 1'b1;
        end
        return d;
    endfunction

    // Model state: what the stage holds after each clock edge.
    bit   m_valid = 0, m_halted = 0, armed = 0;
    int   m_cnt = 0;
    dec_t m_held = '0;

    always @(posedge clk) begin
        bit rdy, ho;
        if (reset) begin
            m_valid = 0; m_halted = 0; m_cnt = 0; m_held = '0; armed = 1;
        end else if (flush) begin
            m_valid = 0; m_halted = 0;
        end else begin
            rdy = !m_halted && (!m_valid || out_ready);
            ho  = m_valid && out_ready;
            if (ho) m_cnt++;
            if (in_valid && rdy) begin
                m_held  = model_dec(int'(instr));
                m_valid = 1;
                if (m_held.opc == 5'd31) m_halted = 1;
            end else if (ho) begin
                m_valid = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("in_ready", 64'(in_ready), 64'(!reset && !m_halted && (!m_valid || out_ready)));
            chk("halted", 64'(halted), 64'(m_halted));
            chk("dec_count", 64'(dec_count), 64'((m_cnt > 255) ? 255 : m_cnt));
            chk("fields", 64'({opcode, amode, rd, rs1, rs2, imm, tgt, shamt, fld_en, illegal}), 64'(m_held));
            chk("out_valid_b", 64'(out_valid_b), 64'(m_valid));
            chk("in_ready_b", 64'(in_ready_b), 64'(!reset && !m_halted && (!m_valid || out_ready)));
            chk("halted_b", 64'(halted_b), 64'(m_halted));
            chk("dec_count_b", 64'(dec_count_b), 64'((m_cnt > 3) ? 3 : m_cnt));
            chk("fields_b", 64'({opcode_b, amode_b, rd_b, rs1_b, rs2_b, imm_b, tgt_b, shamt_b, fld_en_b, illegal_b}), 64'(m_held));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] vec [0:12] = '{16'h07A5, 16'h03C9, 16'h1234, 16'h2D5C, 16'h6ABC,
                                16'h6123, 16'h84F1, 16'h8A36, 16'hC5AA, 16'hCC0F,
                                16'h7800, 16'h4A9B, 16'hAC44};

    initial begin
        reset = 1; flush = 0; in_valid = 0; out_ready = 1; instr = '0;
        tick(); tick();
        @(negedge clk);
        chk("lit_reset_in_ready", 64'(in_ready), 64'd0);
        chk("lit_reset_out_valid", 64'(out_valid), 64'd0);
        chk("lit_reset_count", 64'(dec_count), 64'd0);
        reset = 0;
        tick();

        // ADD amode0
        in_valid = 1; instr = 16'h0AB6; out_ready = 1;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("lit_add_opcode", 64'(opcode), 64'd1);
        chk("lit_add_rd", 64'(rd), 64'd5);
        chk("lit_add_rs1", 64'(rs1), 64'd3);
        chk("lit_add_rs2", 64'(rs2), 64'd3);
        chk("lit_add_fld_en", 64'(fld_en), 64'b000111);
        chk("lit_add_out_valid", 64'(out_valid), 64'd1);
        tick();

        // LOAD held under back-pressure while a new word is offered
        in_valid = 1; instr = 16'h5A50; out_ready = 0;
        tick();
        instr = 16'h0AB6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lit_stall_in_ready", 64'(in_ready), 64'd0);
            chk("lit_stall_opcode", 64'(opcode), 64'd11);
            chk("lit_stall_rd", 64'(rd), 64'd4);
            chk("lit_stall_imm", 64'(imm), 64'd0);
            chk("lit_stall_count", 64'(dec_count), 64'd1);
            tick();
        end
        out_ready = 1;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("lit_swap_opcode", 64'(opcode), 64'd1);
        chk("lit_swap_out_valid", 64'(out_valid), 64'd1);
        chk("lit_swap_count", 64'(dec_count), 64'd2);
        tick();

        // Illegal opcode 0x1A
        in_valid = 1; instr = 16'hD000;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("lit_ill_illegal", 64'(illegal), 64'd1);
        chk("lit_ill_fld_en", 64'(fld_en), 64'd0);
        chk("lit_ill_fields", 64'({rd, rs1, rs2, imm, tgt, shamt}), 64'd0);
        chk("lit_ill_halted", 64'(halted), 64'd0);
        chk("lit_ill_count", 64'(dec_count), 64'd3);
        tick();
        @(negedge clk);
        chk("lit_ill_count_after", 64'(dec_count), 64'd4);
        chk("lit_sat_count_b", 64'(dec_count_b), 64'd3);

        // STORE: tgt=18, rd=3
        in_valid = 1; instr = 16'h6123;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("lit_store_tgt", 64'(tgt), 64'd18);
        chk("lit_store_rd", 64'(rd), 64'd3);
        chk("lit_store_fld_en", 64'(fld_en), 64'b010001);
        tick();

        // ASHL amode1: imm=IH=3, shamt=7
        in_valid = 1; instr = 16'h84F1;
        tick();
        in_valid = 0;
        @(negedge clk);
        chk("lit_ashl_imm", 64'(imm), 64'd3);
        chk("lit_ashl_shamt", 64'(shamt), 64'd7);
        chk("lit_ashl_rd", 64'(rd), 64'd0);
        chk("lit_ashl_fld_en", 64'(fld_en), 64'b101000);
        tick();

        // Back-to-back table with intermittent back-pressure
        for (int i = 0; i < 13; i++) begin
            in_valid = 1; instr = vec[i]; out_ready = (i % 3 != 2);
            tick();
        end
        in_valid = 0; out_ready = 1;
        tick(); tick();

        // HALT then ADD offered
        in_valid = 1; instr = 16'hF800; out_ready = 0;
        tick();
        instr = 16'h0AB6;
        @(negedge clk);
        chk("lit_halt_halted", 64'(halted), 64'd1);
        chk("lit_halt_in_ready", 64'(in_ready), 64'd0);
        chk("lit_halt_opcode", 64'(opcode), 64'd31);
        chk("lit_halt_fld_en", 64'(fld_en), 64'd0);
        tick();
        out_ready = 1;
        tick();
        @(negedge clk);
        chk("lit_halt_drained", 64'(out_valid), 64'd0);
        chk("lit_halt_blocked", 64'(in_ready), 64'd0);
        flush = 1;
        tick();
        flush = 0;
        @(negedge clk);
        chk("lit_flush_halted", 64'(halted), 64'd0);
        chk("lit_flush_out_valid", 64'(out_valid), 64'd0);
        chk("lit_flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        @(negedge clk);
        chk("lit_resume_opcode", 64'(opcode), 64'd1);
        chk("lit_resume_out_valid", 64'(out_valid), 64'd1);

        // Flush beats simultaneous accept and handoff
        flush = 1;
        tick();
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("lit_flush_prio_valid", 64'(out_valid), 64'd0);
        tick();

        // Reset mid-stream with a result held
        in_valid = 1; instr = 16'h5A50; out_ready = 0;
        tick();
        reset = 1;
        tick();
        @(negedge clk);
        chk("lit_rst_out_valid", 64'(out_valid), 64'd0);
        chk("lit_rst_count", 64'(dec_count), 64'd0);
        chk("lit_rst_count_b", 64'(dec_count_b), 64'd0);
        chk("lit_rst_opcode", 64'(opcode), 64'd0);
        chk("lit_rst_in_ready", 64'(in_ready), 64'd0);
        reset = 0; in_valid = 0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
